id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fwd_mux.sv | 24 ++
 rtl/id_ex_stage.sv | 85 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants (XLEN default, ALU op codes, forwarding-select codes)
package cpu_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks MEM, then WB, then register data for one source operand (never forwards x0), reporting the choice on sel
module fwd_mux import cpu_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] data,
  output logic [1:0]      sel
);
  logic mem_hit, wb_hit;
  always_comb begin
    mem_hit = mem_reg_write && (mem_rd_addr == rs_addr) && (rs_addr != '0);
    wb_hit  = wb_reg_write && (wb_rd_addr == rs_addr) && (rs_addr != '0);
    data    = mem_hit ? mem_result : wb_hit ? wb_result : rs_data;
    sel     = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_REG;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall/flush/bubble handling and MEM/WB operand forwarding
module id_ex_stage import cpu_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [2:0]      id_alu_ctrl,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            stall,
  input  logic            flush,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [2:0]      alu_ctrl,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic [XLEN-1:0] ex_store_data,
  output logic [1:0]      fwd_sel1,
  output logic [1:0]      fwd_sel2
);
  logic            v, src, rw;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] d1, d2, imm, f1, f2;
  logic [2:0]      ctrl;
  always_ff @(posedge clk)
    if (!rst_n || flush || (!stall && !id_valid)) begin
      v    <= 1'b0;
      src  <= 1'b0;
      rw   <= 1'b0;
      rs1  <= '0;
      rs2  <= '0;
      rd   <= '0;
      d1   <= '0;
      d2   <= '0;
      imm  <= '0;
      ctrl <= ALU_ADD;
    end else if (!stall) begin
      v    <= 1'b1;
      src  <= id_alu_src;
      rw   <= id_reg_write;
      rs1  <= id_rs1_addr;
      rs2  <= id_rs2_addr;
      rd   <= id_rd_addr;
      d1   <= id_rs1_data;
      d2   <= id_rs2_data;
      imm  <= id_imm;
      ctrl <= id_alu_ctrl;
    end
  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd1 (
    .rs_addr(rs1), .rs_data(d1),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .data(f1), .sel(fwd_sel1)
  );
  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd2 (
    .rs_addr(rs2), .rs_data(d2),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .data(f2), .sel(fwd_sel2)
  );
  always_comb begin
    ex_valid      = v;
    alu_in1       = f1;
    alu_in2       = src ? imm : f2;
    alu_ctrl      = ctrl;
    ex_rd_addr    = rd;
    ex_reg_write  = rw && v;
    ex_store_data = f2;
  end
endmodule
